// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and round-robin helpers for uart_tx_arb
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } arb_state_t;

  localparam int MAX_REQ = 8;

  function automatic logic [2:0] rr_next_index(input logic [2:0] k, input logic [3:0] n);
    if ({1'b0, k} == n - 4'd1) return 3'd0;
    return k + 3'd1;
  endfunction

  // First set bit of req at or after ptr, wrapping modulo n; returns ptr when req is empty.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic [2:0] cur;
    logic [2:0] win;
    logic       found;
    cur   = ptr;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < int'(n) && !found && req[cur]) begin
        win   = cur;
        found = 1'b1;
      end
      cur = rr_next_index(cur, n);
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1-style serializer: start bit, WIDTH data bits LSB first, stop bit
module uart_tx #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 100
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_dv,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_tx
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BIT_W = $clog2(WIDTH + 2);

  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic [WIDTH+1:0] frame_q;
  logic             busy_q;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '1;
    end else if (!busy_q) begin
      if (i_dv) begin
        busy_q  <= 1'b1;
        frame_q <= {1'b1, i_data, 1'b0};
        cnt_q   <= '0;
        bit_q   <= '0;
      end
    end else if (cnt_q == CNT_W'(DIVISOR - 1)) begin
      cnt_q <= '0;
      if (bit_q == BIT_W'(WIDTH + 1)) begin
        busy_q <= 1'b0;
      end else begin
        bit_q   <= bit_q + BIT_W'(1);
        frame_q <= {1'b1, frame_q[WIDTH+1:1]};
      end
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Line is driven from busy so an asserted reset returns it high without waiting for a clock.
  assign o_tx   = busy_q ? frame_q[0] : 1'b1;
  assign o_busy = busy_q;

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one uart_tx; UART_TX_ARB_LOCK_EN adds i_lock
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 100
) (
  input  logic                   clk,
  input  logic                   i_reset_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       i_lock,
`endif
  output logic [N_REQ-1:0]       o_ack,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam logic [3:0] N4 = 4'(N_REQ);

  arb_state_t       state_q;
  arb_state_t       state_nx;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] ack_q;
  logic [N_REQ-1:0] lock_vec;
  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] win_onehot;
  logic [MAX_REQ-1:0] req_ext;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] win_data;
  logic [2:0]       ptr_q;
  logic [2:0]       win;
  logic             lock_hold;
  logic             any_req;
  logic             tx_dv;
  logic             tx_busy;

`ifdef UART_TX_ARB_LOCK_EN
  assign lock_vec = i_lock;
`else
  assign lock_vec = '0;
`endif

  // A grant surviving into IDLE only exists for a locked owner, so this doubles as the lock flag.
  assign lock_hold = |(lock_vec & grant_q);
  assign req_eff   = lock_hold ? (i_req & grant_q) : i_req;
  assign any_req   = |req_eff;

  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req_eff;
  end

  assign win = rr_pick(req_ext, ptr_q, N4);

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == 3'(k)) begin
        win_onehot[k] = 1'b1;
        win_data      = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (any_req)  state_nx = LOAD;
      LOAD:    if (tx_busy)  state_nx = SEND;
      SEND:    if (!tx_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_dv  = (state_q == LOAD);
    o_busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      grant_q <= '0;
      ack_q   <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ack_q   <= win_onehot;
            grant_q <= win_onehot;
            hold_q  <= win_data;
            if (!lock_hold) ptr_q <= rr_next_index(win, N4);
          end else if (!lock_hold) begin
            grant_q <= '0;
          end
        end
        SEND: begin
          if (!tx_busy && !lock_hold) grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_ack   = ack_q;
  assign o_grant = grant_q;

  uart_tx #(
    .WIDTH   (WIDTH),
    .DIVISOR (DIVISOR)
  ) u_uart_tx (
    .clk     (clk),
    .i_reset (!i_reset_n),
    .i_dv    (tx_dv),
    .i_data  (hold_q),
    .o_busy  (tx_busy),
    .o_tx    (o_tx)
  );

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed vector bench for uart_tx_arb; lock sequence under UART_TX_ARB_LOCK_EN
module tb_uart_tx_arb;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 8;

  logic         clk;
  logic         i_reset_n;
  logic [N-1:0] i_req;
  logic [N*W-1:0] i_data;
  logic [N-1:0] o_ack;
  logic [N-1:0] o_grant;
  logic         o_tx;
  logic         o_busy;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0] i_lock;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arb #(.N_REQ(N), .WIDTH(W), .DIVISOR(D)) dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_req),
    .i_data    (i_data),
`ifdef UART_TX_ARB_LOCK_EN
    .i_lock    (i_lock),
`endif
    .o_ack     (o_ack),
    .o_grant   (o_grant),
    .o_tx      (o_tx),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   clr;
    logic [N-1:0]   set;
    logic [N*W-1:0] data;
    int             exp_idx;
    logic [W-1:0]   exp_byte;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic wait_ack(output int idx);
    int lat;
    idx = -1;
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (o_ack != '0) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      fail_timeout("ack_wait");
      return;
    end
    for (int k = 0; k < N; k++) if (o_ack[k]) idx = k;
    check("ack_onehot", $countones(o_ack), 1);
    check("ack_eq_grant", o_grant, o_ack);
  endtask

  task automatic drop_req(input int idx);
    logic [N-1:0] m;
    m = '0;
    if (idx >= 0) m[idx[1:0]] = 1'b1;
    i_req = i_req & ~m;
  endtask

  task automatic wait_start(output bit ok);
    int c;
    c = 0;
    while (o_tx !== 1'b0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    ok = (o_tx === 1'b0);
    if (!ok) fail_timeout("start_bit_wait");
  endtask

  task automatic rx_byte(output logic [W-1:0] b);
    bit ok;
    b = '0;
    wait_start(ok);
    if (!ok) return;
    repeat (D/2) @(negedge clk);
    check("rx_start_bit", o_tx, 0);
    for (int i = 0; i < W; i++) begin
      repeat (D) @(negedge clk);
      b[i] = o_tx;
    end
    repeat (D) @(negedge clk);
    check("rx_stop_bit", o_tx, 1);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_req     = '0;
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int           idx;
    int           cnt;
    int           extra_ack;
    int           bad_runs;
    int           n_ack;
    int           n_low;
    bit           ok;
    logic         level;
    logic [W-1:0] b;

    tbl[0]  = '{4'b0000, 4'b1111, 32'h13121110, 0, 8'h10};
    tbl[1]  = '{4'b0000, 4'b0000, 32'h13121110, 1, 8'h11};
    tbl[2]  = '{4'b0000, 4'b0000, 32'h13121110, 2, 8'h12};
    tbl[3]  = '{4'b0000, 4'b0001, 32'h13121110, 3, 8'h13};
    tbl[4]  = '{4'b0000, 4'b0000, 32'h13121110, 0, 8'h10};
    tbl[5]  = '{4'b0000, 4'b0001, 32'h13121155, 0, 8'h55};
    tbl[6]  = '{4'b0000, 4'b0010, 32'h13122155, 1, 8'h21};
    tbl[7]  = '{4'b0000, 4'b0011, 32'h13123130, 0, 8'h30};
    tbl[8]  = '{4'b0010, 4'b0101, 32'h13423130, 2, 8'h42};
    tbl[9]  = '{4'b0000, 4'b0000, 32'h13423130, 0, 8'h30};
    tbl[10] = '{4'b0000, 4'b1000, 32'hC3423130, 3, 8'hC3};
    tbl[11] = '{4'b0000, 4'b0110, 32'hC37E8130, 1, 8'h81};
    tbl[12] = '{4'b0000, 4'b0000, 32'hC37E8130, 2, 8'h7E};

    i_reset_n = 1'b0;
    i_req     = '0;
    i_data    = '0;
`ifdef UART_TX_ARB_LOCK_EN
    i_lock    = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_tx", o_tx, 1);
    check("rst_grant", o_grant, 0);
    check("rst_ack", o_ack, 0);
    check("rst_busy", o_busy, 0);
    i_reset_n = 1'b1;
    @(negedge clk);

    // Single request: one-cycle ack latency and exact bit timing of 0x55.
    i_data = 32'h00000055;
    i_req  = 4'b0001;
    @(negedge clk);
    check("single_ack_latency", o_ack, 4'b0001);
    check("single_grant", o_grant, 4'b0001);
    check("single_busy", o_busy, 1);
    i_req = '0;
    wait_start(ok);
    if (ok) begin
      level     = 1'b0;
      extra_ack = 0;
      bad_runs  = 0;
      for (int r = 0; r < 9; r++) begin
        cnt = 0;
        while (o_tx === level && cnt < 3*D) begin
          @(negedge clk);
          cnt++;
          if (o_ack != '0) extra_ack++;
        end
        if (cnt != D) bad_runs++;
        level = ~level;
      end
      check("single_bit_periods_bad", bad_runs, 0);
      check("single_extra_ack", extra_ack, 0);
      cnt = 0;
      while (o_busy === 1'b1 && cnt < 3*D) begin
        @(negedge clk);
        cnt++;
      end
      check("single_busy_fall_window", (cnt >= D && cnt <= D + 2), 1);
      check("single_idle_tx", o_tx, 1);
      check("single_idle_grant", o_grant, 0);
    end

    do_reset();
    for (int r = 0; r < 13; r++) begin
      i_req  = (i_req & ~tbl[r].clr) | tbl[r].set;
      i_data = tbl[r].data;
      wait_ack(idx);
      check($sformatf("vec%0d_winner", r), idx, tbl[r].exp_idx);
      drop_req(idx);
      rx_byte(b);
      check($sformatf("vec%0d_byte", r), b, tbl[r].exp_byte);
    end

    // Data change after ack must not reach the line.
    repeat (2*D) @(negedge clk);
    i_data = 32'h000000A5;
    i_req  = 4'b0001;
    wait_ack(idx);
    check("late_data_winner", idx, 0);
    drop_req(idx);
    @(negedge clk);
    i_data = 32'h000000FF;
    rx_byte(b);
    check("late_data_byte", b, 8'hA5);

    // Reset in the middle of data bit 3 (0x07 -> bit 3 low).
    repeat (2*D) @(negedge clk);
    i_data = 32'h00000700;
    i_req  = 4'b0010;
    wait_ack(idx);
    check("rst_mid_winner", idx, 1);
    drop_req(idx);
    wait_start(ok);
    if (ok) begin
      repeat (D/2 + 4*D) @(negedge clk);
      check("rst_mid_tx_before", o_tx, 0);
      #2 i_reset_n = 1'b0;
      #1;
      check("rst_mid_grant", o_grant, 0);
      check("rst_mid_busy", o_busy, 0);
      check("rst_mid_tx", o_tx, 1);
      check("rst_mid_ack", o_ack, 0);
      repeat (2) @(negedge clk);
      check("rst_hold_tx", o_tx, 1);
      i_reset_n = 1'b1;
      n_ack = 0;
      n_low = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (o_ack != '0) n_ack++;
        if (o_tx !== 1'b1) n_low++;
      end
      check("rst_no_replay_ack", n_ack, 0);
      check("rst_no_replay_tx", n_low, 0);
      i_data = 32'h44332211;
      i_req  = 4'b1111;
      @(negedge clk);
      check("rst_first_grant", o_ack, 4'b0001);
    end

`ifdef UART_TX_ARB_LOCK_EN
    do_reset();
    i_lock = 4'b0010;
    i_data = 32'h63627160;
    i_req  = 4'b0010;
    wait_ack(idx);
    check("lock_first", idx, 1);
    i_req  = 4'b1111;
    i_data = 32'h63627260;
    for (int k = 1; k < 3; k++) begin
      wait_ack(idx);
      check($sformatf("lock_repeat%0d", k), idx, 1);
      if (k == 1) begin
        i_data = 32'h63627360;
      end else begin
        drop_req(1);
        i_lock = '0;
      end
    end
    wait_ack(idx);
    check("lock_release_next", idx, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
